// File: rtl/butterfly_dit.sv
// butterfly_dit: radix-2 decimation-in-time butterfly for the DIT/IFFT pipeline.
//   sum_out  = up + W*down,  diff_out = up - W*down,  W = exp(-j*2*pi*k/N), N = 2^SET.
//   The twiddle index k comes from an internal pair counter (reset/clr to 0, +1 per accepted pair).
//   Latency 6 cycles (4 multiply + 2 add/sub), one pair per cycle, no backpressure.
// Data samples are 16-bit signed re/im; twiddles are Q2.14 so +1.0 (16384) is exact.
// Optional build macro BUTTERFLY_DIT_IFFT_EN: conjugated twiddle W = exp(+j*2*pi*k/N).
// Contents: fft_pkg (bus type, saturation, twiddle generator), pipe_reg, FFT_cmult,
// FFT_cadd, FFT_csub and the butterfly_dit top.

package fft_pkg;

    localparam int DW      = 16;
    localparam int TW_FRAC = 14;

    typedef struct packed {
        logic                 valid;
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } FFT_DATA_BUS;

    // Clamp a wide signed value into the sample range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [33:0] x);
        if (x > 34'sd32767) begin
            return 16'sh7fff;
        end else if (x < -34'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[DW-1:0];
        end
    endfunction

    // Elaboration-time twiddle generator: round(2^14 * cos or sin(2*pi*k / 2^log2n)).
    // Integer Taylor series in Q30 after folding the angle into [0, pi/2].
    function automatic int twiddle_q14(input int k, input int log2n, input logic want_sin);
        longint pi_q30;
        longint half_pi;
        longint x;
        longint term;
        longint acc;
        longint prod;
        longint denom;
        logic   neg;
        pi_q30  = 64'sd3373259426;
        half_pi = pi_q30 >>> 1;
        x       = (64'sd2 * pi_q30 * longint'(k)) >>> log2n;
        neg     = 1'b0;
        if (x > half_pi) begin
            x   = pi_q30 - x;
            neg = ~want_sin;
        end
        acc  = want_sin ? x : (64'sd1 <<< 30);
        term = acc;
        for (int unsigned i = 0; i < 12; i++) begin
            denom = want_sin ? longint'((2*i + 2) * (2*i + 3))
                             : longint'((2*i + 1) * (2*i + 2));
            prod  = (term * x) >>> 30;
            prod  = (prod * x) >>> 30;
            term  = -(prod / denom);
            acc   = acc + term;
        end
        if (neg) begin
            acc = -acc;
        end
        return int'((acc + 64'sd32768) >>> 16);
    endfunction

endpackage

// pipe_reg: DEPTH-stage register delay line with asynchronous clear.
module pipe_reg #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift din through DEPTH registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];
endmodule

// FFT_cmult: 4-cycle complex multiply a*b, b in Q2.14, rounded and saturated to 16 bits.
module FFT_cmult
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    output logic signed [DW-1:0] p_re,
    output logic signed [DW-1:0] p_im
);
    localparam logic signed [2*DW:0] ROUND = 33'sd1 <<< (TW_FRAC - 1);

    logic signed [DW-1:0]   ar_q, ai_q, br_q, bi_q;
    logic signed [2*DW-1:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [2*DW:0]   re_q, im_q;

    // Stage 1: register operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q <= '0;
            ai_q <= '0;
            br_q <= '0;
            bi_q <= '0;
        end else begin
            ar_q <= a_re;
            ai_q <= a_im;
            br_q <= b_re;
            bi_q <= b_im;
        end
    end

    // Stage 2: four partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            ir_q <= '0;
        end else begin
            rr_q <= ar_q * br_q;
            ii_q <= ai_q * bi_q;
            ri_q <= ar_q * bi_q;
            ir_q <= ai_q * br_q;
        end
    end

    // Stage 3: combine into full-precision real and imaginary parts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_q <= '0;
            im_q <= '0;
        end else begin
            re_q <= 33'(rr_q) - 33'(ii_q);
            im_q <= 33'(ri_q) + 33'(ir_q);
        end
    end

    // Stage 4: round-half-up back to sample scale and saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_re <= '0;
            p_im <= '0;
        end else begin
            p_re <= sat_dw(34'((re_q + ROUND) >>> TW_FRAC));
            p_im <= sat_dw(34'((im_q + ROUND) >>> TW_FRAC));
        end
    end
endmodule

// FFT_cadd: 2-cycle saturating complex add.
module FFT_cadd
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    output logic signed [DW-1:0] s_re,
    output logic signed [DW-1:0] s_im
);
    logic signed [DW:0] s_re_q, s_im_q;

    // Stage 1: one-bit-wider sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_re_q <= '0;
            s_im_q <= '0;
        end else begin
            s_re_q <= (DW+1)'(a_re) + (DW+1)'(b_re);
            s_im_q <= (DW+1)'(a_im) + (DW+1)'(b_im);
        end
    end

    // Stage 2: saturate to sample width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_re <= '0;
            s_im <= '0;
        end else begin
            s_re <= sat_dw(34'(s_re_q));
            s_im <= sat_dw(34'(s_im_q));
        end
    end
endmodule

// FFT_csub: 2-cycle saturating complex subtract a - b.
module FFT_csub
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    output logic signed [DW-1:0] d_re,
    output logic signed [DW-1:0] d_im
);
    logic signed [DW:0] d_re_q, d_im_q;

    // Stage 1: one-bit-wider difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_re_q <= '0;
            d_im_q <= '0;
        end else begin
            d_re_q <= (DW+1)'(a_re) - (DW+1)'(b_re);
            d_im_q <= (DW+1)'(a_im) - (DW+1)'(b_im);
        end
    end

    // Stage 2: saturate to sample width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_re <= '0;
            d_im <= '0;
        end else begin
            d_re <= sat_dw(34'(d_re_q));
            d_im <= sat_dw(34'(d_im_q));
        end
    end
endmodule

// butterfly_dit: twiddle multiply on down, then add/subtract against delayed up.
module butterfly_dit
    import fft_pkg::*;
#(
    parameter int SET = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  FFT_DATA_BUS    up,
    input  FFT_DATA_BUS    down,
    input  logic           clr,
    output FFT_DATA_BUS    sum_out,
    output FFT_DATA_BUS    diff_out,
    output logic [SET-2:0] tw_idx
);
    localparam int HALF = 1 << (SET - 1);

    logic                 accept;
    logic [SET-2:0]       k_q;
    logic signed [DW-1:0] tw_re_tab [HALF];
    logic signed [DW-1:0] tw_im_tab [HALF];
    logic signed [DW-1:0] tw_re, tw_im;
    logic signed [DW-1:0] mul_a_re, mul_a_im, mul_b_re, mul_b_im;
    logic signed [DW-1:0] prod_re, prod_im;
    logic [2*DW-1:0]      up_d4;
    logic                 mult_valid;
    logic                 out_valid;
    logic signed [DW-1:0] add_a_re, add_a_im, add_b_re, add_b_im;
    logic signed [DW-1:0] sum_re, sum_im, diff_re, diff_im;

    // Forward twiddle table: re = cos, im = -sin, both Q2.14; entry 0 is exactly +1.
    for (genvar g = 0; g < HALF; g++) begin : g_tw
        localparam int TW_RE = twiddle_q14(g, SET, 1'b0);
        localparam int TW_IM = -twiddle_q14(g, SET, 1'b1);
        assign tw_re_tab[g] = TW_RE[DW-1:0];
        assign tw_im_tab[g] = TW_IM[DW-1:0];
    end

    assign accept = up.valid & down.valid;
    assign tw_idx = k_q;

    // Pair counter: clear wins over increment; wraps naturally at 2^(SET-1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
        end else if (clr) begin
            k_q <= '0;
        end else if (accept) begin
            k_q <= k_q + 1'b1;
        end
    end

    // Twiddle lookup at the current k (the accepted pair sees k before any update).
    always_comb begin
        tw_re = tw_re_tab[k_q];
`ifdef BUTTERFLY_DIT_IFFT_EN
        tw_im = -tw_im_tab[k_q];
`else
        tw_im = tw_im_tab[k_q];
`endif
    end

    // Multiplier operands are zero unless a pair is accepted.
    always_comb begin
        mul_a_re = '0;
        mul_a_im = '0;
        mul_b_re = '0;
        mul_b_im = '0;
        if (accept) begin
            mul_a_re = down.re;
            mul_a_im = down.im;
            mul_b_re = tw_re;
            mul_b_im = tw_im;
        end
    end

    FFT_cmult u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .a_re  (mul_a_re),
        .a_im  (mul_a_im),
        .b_re  (mul_b_re),
        .b_im  (mul_b_im),
        .p_re  (prod_re),
        .p_im  (prod_im)
    );

    pipe_reg #(.WIDTH(2*DW), .DEPTH(4)) u_up_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({up.re, up.im}),
        .dout  (up_d4)
    );

    pipe_reg #(.WIDTH(1), .DEPTH(4)) u_valid_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (accept),
        .dout  (mult_valid)
    );

    pipe_reg #(.WIDTH(1), .DEPTH(2)) u_valid_out (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (mult_valid),
        .dout  (out_valid)
    );

    // Add/sub operands are zero when the delayed valid is low, so bubbles leave zero data.
    always_comb begin
        add_a_re = '0;
        add_a_im = '0;
        add_b_re = '0;
        add_b_im = '0;
        if (mult_valid) begin
            add_a_re = $signed(up_d4[2*DW-1:DW]);
            add_a_im = $signed(up_d4[DW-1:0]);
            add_b_re = prod_re;
            add_b_im = prod_im;
        end
    end

    FFT_cadd u_add (
        .clk   (clk),
        .rst_n (rst_n),
        .a_re  (add_a_re),
        .a_im  (add_a_im),
        .b_re  (add_b_re),
        .b_im  (add_b_im),
        .s_re  (sum_re),
        .s_im  (sum_im)
    );

    FFT_csub u_sub (
        .clk   (clk),
        .rst_n (rst_n),
        .a_re  (add_a_re),
        .a_im  (add_a_im),
        .b_re  (add_b_re),
        .b_im  (add_b_im),
        .d_re  (diff_re),
        .d_im  (diff_im)
    );

    assign sum_out  = '{valid: out_valid, re: sum_re,  im: sum_im};
    assign diff_out = '{valid: out_valid, re: diff_re, im: diff_im};
endmodule

// File: tb/tb_butterfly_dit.sv
// Self-checking bench for butterfly_dit at SET=3 (N=8, k in 0..3).
// Expected outputs come from a real-valued twiddle model pushed to a scoreboard
// queue at drive time and popped when the DUT raises valid.
`timescale 1ns/1ps
module tb_butterfly_dit;
    import fft_pkg::*;

    localparam int SET = 3;
    localparam int NK  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr = 1'b0;
    FFT_DATA_BUS    up = '0;
    FFT_DATA_BUS    down = '0;
    FFT_DATA_BUS    sum_out, diff_out;
    logic [SET-2:0] tw_idx;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int k_model = 0;

    typedef struct {
        int due;
        int sr;
        int si;
        int dr;
        int di;
        int tol;
    } exp_t;
    exp_t sb[$];

    butterfly_dit #(.SET(SET)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .up       (up),
        .down     (down),
        .clr      (clr),
        .sum_out  (sum_out),
        .diff_out (diff_out),
        .tw_idx   (tw_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat(input int x);
        return (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int sv(input logic signed [15:0] x);
        return int'(x);
    endfunction

    // Butterfly reference: quantised twiddle, real-valued product rounded to nearest.
    function automatic exp_t model(input int ur, input int ui, input int dr, input int di, input int k);
        exp_t e;
        real  ang;
        int   qr, qi, pr, pim;
        ang = 2.0 * 3.14159265358979 * real'(k) / 8.0;
        qr  = int'(16384.0 * $cos(ang));
`ifdef BUTTERFLY_DIT_IFFT_EN
        qi  = int'(16384.0 * $sin(ang));
`else
        qi  = -int'(16384.0 * $sin(ang));
`endif
        pr    = sat(int'(real'(dr * qr - di * qi) / 16384.0));
        pim   = sat(int'(real'(dr * qi + di * qr) / 16384.0));
        e.sr  = sat(ur + pr);
        e.si  = sat(ui + pim);
        e.dr  = sat(ur - pr);
        e.di  = sat(ui - pim);
        e.tol = k % 2;
        e.due = 0;
        return e;
    endfunction

    // Present one cycle of inputs (called at posedge+1), record expectation, track k.
    task automatic drive(input logic uv, input logic dv, input int ur, input int ui,
                         input int dr, input int di, input logic c);
        exp_t e;
        up   = '{valid: uv, re: 16'(ur), im: 16'(ui)};
        down = '{valid: dv, re: 16'(dr), im: 16'(di)};
        clr  = c;
        if (uv && dv) begin
            e     = model(ur, ui, dr, di, k_model);
            e.due = cyc + 6;
            sb.push_back(e);
        end
        if (c) k_model = 0;
        else if (uv && dv) k_model = (k_model + 1) % NK;
        @(posedge clk);
        #1;
        up   = '0;
        down = '0;
        clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sum_out !== '0) begin n_bad++; $display("FAIL reset_sum: got %h want 0", sum_out); end
        n_cmp++;
        if (diff_out !== '0) begin n_bad++; $display("FAIL reset_diff: got %h want 0", diff_out); end
        n_cmp++;
        if (tw_idx !== '0) begin n_bad++; $display("FAIL reset_tw_idx: got %0d want 0", tw_idx); end
        rst_n   = 1'b1;
        k_model = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_identity();
        exp_t e;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        drive(1'b1, 1'b1, 3, 1, 1, 2, 1'b0);
        sb[0].sr = 4; sb[0].si = 3; sb[0].dr = 2; sb[0].di = -1; sb[0].tol = 0;
        n_cmp++;
        if (tw_idx !== 2'd1) begin n_bad++; $display("FAIL identity_tw_idx: got %0d want 1", tw_idx); end
        for (int t = 0; t < 20 && sb.size() > 0; t++) begin
            @(negedge clk);
            if (sum_out.valid || diff_out.valid) begin
                e = sb.pop_front();
                n_cmp++;
                if (cyc != e.due || sum_out.valid !== 1'b1 || diff_out.valid !== 1'b1 ||
                    sv(sum_out.re) != e.sr || sv(sum_out.im) != e.si ||
                    sv(diff_out.re) != e.dr || sv(diff_out.im) != e.di) begin
                    n_bad++;
                    $display("FAIL identity_out: got cyc=%0d sum=(%0d,%0d) diff=(%0d,%0d) want cyc=%0d sum=(%0d,%0d) diff=(%0d,%0d)",
                             cyc, sv(sum_out.re), sv(sum_out.im), sv(diff_out.re), sv(diff_out.im),
                             e.due, e.sr, e.si, e.dr, e.di);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL identity_timeout: %0d pending want 0", sb.size()); sb.delete(); end
        @(negedge clk);
        n_cmp++;
        if (sum_out.valid !== 1'b0 || diff_out.valid !== 1'b0)
            begin n_bad++; $display("FAIL identity_single_cycle: valid=%b/%b want 0/0", sum_out.valid, diff_out.valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 3, 1, 1, 2, 1'b0);
`ifdef BUTTERFLY_DIT_IFFT_EN
        sb[2].sr = 1; sb[2].si = 2; sb[2].dr = 5; sb[2].di = 0;
`else
        sb[2].sr = 5; sb[2].si = 0; sb[2].dr = 1; sb[2].di = 2;
`endif
        n_cmp++;
        if (tw_idx !== 2'd0) begin n_bad++; $display("FAIL b2b_wrap_tw_idx: got %0d want 0", tw_idx); end
        for (int t = 0; t < 20 && sb.size() > 0; t++) begin
            @(negedge clk);
            if (sum_out.valid || diff_out.valid) begin
                e = sb.pop_front();
                n_cmp++;
                if (cyc != e.due || sum_out.valid !== 1'b1 || diff_out.valid !== 1'b1 ||
                    iabs(sv(sum_out.re) - e.sr) > e.tol || iabs(sv(sum_out.im) - e.si) > e.tol ||
                    iabs(sv(diff_out.re) - e.dr) > e.tol || iabs(sv(diff_out.im) - e.di) > e.tol) begin
                    n_bad++;
                    $display("FAIL b2b_out: got cyc=%0d sum=(%0d,%0d) diff=(%0d,%0d) want cyc=%0d sum=(%0d,%0d) diff=(%0d,%0d)",
                             cyc, sv(sum_out.re), sv(sum_out.im), sv(diff_out.re), sv(diff_out.im),
                             e.due, e.sr, e.si, e.dr, e.di);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_timeout: %0d pending want 0", sb.size()); sb.delete(); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mismatch();
        logic [SET-2:0] k_before;
        int seen;
        seen     = 0;
        k_before = tw_idx;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 3, 1, 1, 2, 1'b0);
        drive(1'b0, 1'b1, 3, 1, 1, 2, 1'b0);
        n_cmp++;
        if (tw_idx !== k_before) begin n_bad++; $display("FAIL mismatch_tw_idx: got %0d want %0d", tw_idx, k_before); end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (sum_out.valid || diff_out.valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL mismatch_valid: got %0d valid cycles want 0", seen); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clr_collision();
        exp_t e;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        drive(1'b1, 1'b1, 100, 200, 1000, 2000, 1'b0);
        drive(1'b1, 1'b1, 100, 200, 1000, 2000, 1'b1);
        n_cmp++;
        if (tw_idx !== 2'd0) begin n_bad++; $display("FAIL clr_tw_idx: got %0d want 0", tw_idx); end
        for (int t = 0; t < 20 && sb.size() > 0; t++) begin
            @(negedge clk);
            if (sum_out.valid || diff_out.valid) begin
                e = sb.pop_front();
                n_cmp++;
                if (cyc != e.due || sum_out.valid !== 1'b1 || diff_out.valid !== 1'b1 ||
                    iabs(sv(sum_out.re) - e.sr) > e.tol || iabs(sv(sum_out.im) - e.si) > e.tol ||
                    iabs(sv(diff_out.re) - e.dr) > e.tol || iabs(sv(diff_out.im) - e.di) > e.tol) begin
                    n_bad++;
                    $display("FAIL clr_out: got cyc=%0d sum=(%0d,%0d) diff=(%0d,%0d) want cyc=%0d sum=(%0d,%0d) diff=(%0d,%0d)",
                             cyc, sv(sum_out.re), sv(sum_out.im), sv(diff_out.re), sv(diff_out.im),
                             e.due, e.sr, e.si, e.dr, e.di);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL clr_timeout: %0d pending want 0", sb.size()); sb.delete(); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midflight();
        int seen;
        seen = 0;
        drive(1'b1, 1'b1, 3, 1, 1, 2, 1'b0);
        drive(1'b1, 1'b1, 3, 1, 1, 2, 1'b0);
        up   = '{valid: 1'b1, re: 16'sd3, im: 16'sd1};
        down = '{valid: 1'b1, re: 16'sd1, im: 16'sd2};
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tw_idx !== '0 || sum_out.valid !== 1'b0 || diff_out.valid !== 1'b0)
            begin n_bad++; $display("FAIL midflight_async: tw_idx=%0d valid=%b/%b want 0 0/0", tw_idx, sum_out.valid, diff_out.valid); end
        #8 rst_n = 1'b1;
        up   = '0;
        down = '0;
        sb.delete();
        k_model = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (sum_out.valid || diff_out.valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL midflight_valid: got %0d valid cycles want 0", seen); end
        n_cmp++;
        if (sum_out !== '0 || diff_out !== '0 || tw_idx !== '0)
            begin n_bad++; $display("FAIL midflight_zero: sum=%h diff=%h tw_idx=%0d want 0 0 0", sum_out, diff_out, tw_idx); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        logic done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 32; i++) begin
                    int r;
                    r = int'($urandom_range(0, 7));
                    drive(r != 0 && r != 2, r != 0 && r != 1,
                          int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 40000)) - 20000,
                          int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 40000)) - 20000,
                          $urandom_range(0, 9) == 0);
                end
                n_cmp++;
                if (tw_idx !== 2'(k_model)) begin n_bad++; $display("FAIL stream_tw_idx: got %0d want %0d", tw_idx, k_model); end
                done = 1'b1;
            end
            begin
                exp_t e;
                for (int t = 0; t < 80 && !(done && sb.size() == 0); t++) begin
                    @(negedge clk);
                    if (sum_out.valid || diff_out.valid) begin
                        n_cmp++;
                        if (sb.size() == 0) begin
                            n_bad++;
                            $display("FAIL stream_spurious: got valid at cyc=%0d want none", cyc);
                        end else begin
                            e = sb.pop_front();
                            if (cyc != e.due || sum_out.valid !== 1'b1 || diff_out.valid !== 1'b1 ||
                                iabs(sv(sum_out.re) - e.sr) > e.tol || iabs(sv(sum_out.im) - e.si) > e.tol ||
                                iabs(sv(diff_out.re) - e.dr) > e.tol || iabs(sv(diff_out.im) - e.di) > e.tol) begin
                                n_bad++;
                                $display("FAIL stream_out: got cyc=%0d sum=(%0d,%0d) diff=(%0d,%0d) want cyc=%0d sum=(%0d,%0d) diff=(%0d,%0d)",
                                         cyc, sv(sum_out.re), sv(sum_out.im), sv(diff_out.re), sv(diff_out.im),
                                         e.due, e.sr, e.si, e.dr, e.di);
                            end
                        end
                    end
                end
            end
        join
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL stream_timeout: %0d pending want 0", sb.size()); sb.delete(); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_back_to_back();
        test_mismatch();
        test_clr_collision();
        test_stream();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/butterfly_dit.md
Name: butterfly_dit

Overview:
- Decimation-in-time radix-2 butterfly. It is the counterpart of the existing DIF stage butterfly.
- The twiddle multiply is applied first, to the down operand; the add and subtract follow.
  - sum_out  = up + W·down
  - diff_out = up − W·down
- The twiddle index is generated inside the block by a pair counter.
- Sits in the DIT/IFFT pipeline, fed by the bit-reversal reorder buffer. Built from the existing FFT_cmult, FFT_cadd, FFT_csub and pipe_reg primitives.

Parameters:
- SET, 4, log2 of the transform size N = 2^SET. The twiddle index range is 0..2^(SET-1)−1. Legal values are 3..10.

Ports:
- clk, input, 1, clock (rising edge).
- rst_n, input, 1, asynchronous active-low reset.
- up, input, FFT_DATA_BUS, upper operand (valid plus complex sample).
- down, input, FFT_DATA_BUS, lower operand. It is multiplied by the twiddle.
- clr, input, 1, synchronous clear of the twiddle index counter, used at frame start.
- sum_out, output, FFT_DATA_BUS, up + W·down.
- diff_out, output, FFT_DATA_BUS, up − W·down.
- tw_idx, output, SET-1, current twiddle index, for debug and verification.

Behaviour:
- Accept condition: a pair is accepted when up.valid && down.valid.
  - If only one valid is high, the sample is dropped, nothing propagates, and the counter does not advance.
- Input gating:
  - Multiplier operands are forced to 0 when no pair is accepted.
  - Adder and subtractor operands are forced to 0 when the delayed valid is low.
  - Outputs never carry stale data with valid high.
- Pipeline:
  - Cycle 0: down × W in FFT_cmult, 4 cycles.
  - In parallel: up is delayed 4 cycles by pipe_reg.
  - Cycle 4: FFT_cadd and FFT_csub on (up_d4, prod), 2 cycles.
  - Total latency is 6 cycles, for both outputs simultaneously.
  - Throughput is one pair per cycle. There is no backpressure.
- Valid path:
  - pipe_reg, 1 bit × 4 stages, into mult_valid.
  - Then 1 bit × 2 stages, into sum_out.valid and diff_out.valid (identical signals).
- Twiddle index counter k (SET-1 bits):
  - Reset value is 0.
  - Increments by 1 on each accepted pair.
  - Wraps from 2^(SET-1)−1 to 0.
  - W is sampled using the value of k in the same cycle as the accepted down sample.
- Twiddle value:
  - W = exp(−j2πk/N).
  - Q format and quantised table are identical to the codebase twiddle tables for the same SET and index.
  - k=0 gives exactly +1.
- clr behaviour:
  - clr=1 forces k to 0 at the next edge.
  - clr together with an accepted pair in the same cycle: that pair uses the old k, and k becomes 0 (clear wins over increment).
  - Data already in flight is unaffected by clr.
- Arithmetic: widths, rounding and saturation are inherited unchanged from FFT_cmult, FFT_cadd and FFT_csub. This block adds no extra scaling.
- Reset:
  - rst_n low asynchronously clears k, all valid pipeline stages, and all data registers to 0.
  - sum_out and diff_out are 0 with valid=0. tw_idx=0.
  - Reset mid-frame discards every in-flight pair. No output valid pulses for pairs accepted before reset.
- Gaps: bubbles (both valids low) hold k and create matching bubbles 6 cycles later.

Optional Feature:
- Macro: BUTTERFLY_DIT_IFFT_EN.
- Defined: the twiddle is conjugated, W = exp(+j2πk/N). This is done by negating the imaginary part of the table value before the multiply. Latency is unchanged. The block computes an inverse-transform stage.
- Undefined: forward twiddle as above. No conjugation logic is present.

Test Plan:
- Identity twiddle. SET=3, reset, clr. Pair up=(3,1), down=(1,2) at k=0 → 6 cycles later sum_out=(4,3), diff_out=(2,−1), both valid for 1 cycle, tw_idx then 1.
- W=−j. SET=3, stream 4 back-to-back pairs, all up=(3,1), down=(1,2).
  - The third pair (k=2) → sum=(5,0), diff=(1,2).
  - Outputs arrive on 4 consecutive cycles, with k returning to 0 after the fourth pair (wrap).
- Mismatched valid. up.valid=1, down.valid=0 for 3 cycles → no output valid, and tw_idx unchanged.
- clr collision. Assert clr in the same cycle as a pair at k=1 → that pair uses W_8^1 (within 1 LSB), and tw_idx=0 next cycle.
- Reset mid-flight. Accept 3 pairs, drop rst_n on cycle 2 for 1 cycle → no valid ever appears on the outputs, outputs are 0, tw_idx=0.
- IFFT (BUTTERFLY_DIT_IFFT_EN defined). SET=3, k=2, up=(3,1), down=(1,2) → sum=(1,2), diff=(5,0) after 6 cycles.
